softusb_rx: RTL

Receive front-end for one SoftUSB port. Sits between the port's transceiver pins (`rcv`/`vp`/`vm`) and the SIE receive logic. Recovers bit timing from the oversampled line, NRZI-decodes, removes stuffed bits, detects SYNC and EOP, and delivers packet bytes with a one-cycle strobe. One instance per port (A, B).

---
 rtl/softusb_rx.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/softusb_rx.sv
// softusb_rx: SoftUSB receive front-end (sync, DPLL, NRZI decode, unstuff, SYNC/EOP detect, byte assembly)
// Ports:
//   usb_clk     48 MHz clock
//   usb_rst_n   synchronous active-low reset
//   rx_en       receiver enable (low while the SIE transmits)
//   speed       1 = full speed (4 clocks/bit), 0 = low speed (32 clocks/bit)
//   rcv/vp/vm   asynchronous transceiver outputs
//   rx_active   high from end of SYNC until EOP or error
//   rx_data     last assembled byte, LSB first on the wire
//   rx_strobe   one-cycle pulse, rx_data valid
//   rx_eop      one-cycle pulse at end of packet
//   rx_error    one-cycle pulse on stuff/alignment error
module softusb_rx (
    input  logic       usb_clk,
    input  logic       usb_rst_n,
    input  logic       rx_en,
    input  logic       speed,
    input  logic       rcv,
    input  logic       vp,
    input  logic       vm,
    output logic       rx_active,
    output logic [7:0] rx_data,
    output logic       rx_strobe,
    output logic       rx_eop,
    output logic       rx_error
);
    typedef enum logic [1:0] {IDLE, SYNC, DATA, ERRW} state_t;
    state_t state, state_n;
    logic [1:0] rcv_sr, vp_sr, vm_sr;
    logic [4:0] ph;
    logic [3:0] cnt, cnt_n;
    logic [2:0] ones, ones_n;
    logic [7:0] sh, sh_n, data_n;
    logic prev_j, prev_j_n, se0_seen, se0_seen_n;
    logic strobe_n, eop_n, err_n;
    logic bs, se0, j, d;
    assign se0 = !vp_sr[1] && !vm_sr[1];
    assign j = rcv_sr[1] == speed;
    assign bs = ph == (speed ? 5'd2 : 5'd16);
    assign d = j == prev_j;
    assign rx_active = state == DATA;
    always_ff @(posedge usb_clk) begin
        if (!usb_rst_n) state <= IDLE;
        else state <= state_n;
    end
    always_ff @(posedge usb_clk) begin
        if (!usb_rst_n) begin
            rcv_sr <= '0;
            vp_sr <= '0;
            vm_sr <= '0;
            ph <= '0;
            cnt <= '0;
            ones <= '0;
            sh <= '0;
            prev_j <= 1'b1;
            se0_seen <= 1'b0;
            rx_data <= '0;
            rx_strobe <= 1'b0;
            rx_eop <= 1'b0;
            rx_error <= 1'b0;
        end else begin
            rcv_sr <= {rcv_sr[0], rcv};
            vp_sr <= {vp_sr[0], vp};
            vm_sr <= {vm_sr[0], vm};
            // clear in step with the new level appearing on the synchronised line
            ph <= (rcv_sr[0] != rcv_sr[1]) ? 5'd0 : (ph + 5'd1) & (speed ? 5'd3 : 5'd31);
            cnt <= cnt_n;
            ones <= ones_n;
            sh <= sh_n;
            prev_j <= prev_j_n;
            se0_seen <= se0_seen_n;
            rx_data <= data_n;
            rx_strobe <= strobe_n;
            rx_eop <= eop_n;
            rx_error <= err_n;
        end
    end
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        ones_n = ones;
        sh_n = sh;
        prev_j_n = prev_j;
        se0_seen_n = se0_seen;
        data_n = rx_data;
        strobe_n = 1'b0;
        eop_n = 1'b0;
        err_n = 1'b0;
        if (!rx_en) state_n = IDLE;
        else if (bs) begin
            case (state)
                IDLE: if (!se0 && !j) begin
                    state_n = SYNC;
                    prev_j_n = 1'b0;
                    cnt_n = '0;
                end
                SYNC: begin
                    if (se0) state_n = IDLE;
                    else if (!j && !prev_j) begin
                        state_n = DATA;
                        cnt_n = '0;
                        ones_n = '0;
                        se0_seen_n = 1'b0;
                    end else if (cnt == 4'd8) state_n = IDLE;
                    else begin
                        cnt_n = cnt + 4'd1;
                        prev_j_n = j;
                    end
                end
                DATA: begin
                    if (se0) se0_seen_n = 1'b1;
                    else if (se0_seen) begin
                        // SE0 then J ends the packet; SE0 then K is treated as a broken line
                        se0_seen_n = 1'b0;
                        state_n = j ? IDLE : ERRW;
                        eop_n = j;
                        err_n = !j || cnt != 4'd0;
                    end else begin
                        prev_j_n = j;
                        if (ones == 3'd6 && !d) ones_n = '0;
                        else begin
                            // a seventh 1 is still shifted in so a byte it completes is delivered
                            ones_n = d ? ones + 3'd1 : 3'd0;
                            sh_n = {d, sh[7:1]};
                            cnt_n = {1'b0, cnt[2:0] + 3'd1};
                            if (cnt[2:0] == 3'd7) begin
                                data_n = {d, sh[7:1]};
                                strobe_n = 1'b1;
                            end
                            if (ones == 3'd6) begin
                                state_n = ERRW;
                                err_n = 1'b1;
                                se0_seen_n = 1'b0;
                            end
                        end
                    end
                end
                ERRW: begin
                    if (se0) se0_seen_n = 1'b1;
                    else if (se0_seen) begin
                        se0_seen_n = 1'b0;
                        if (j) state_n = IDLE;
                    end
                end
            endcase
        end
    end
endmodule
